// File: rtl/bsg_fifo_reorder_pkg.sv
// ============================================================================
// bsg_fifo_reorder_pkg
// Pointer-width helpers and modulo pointer arithmetic for the reorder FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bsg_fifo_reorder_pkg;

    // A slot index needs lg_els_lp bits; the extra wrap bit tells full from empty.
    function automatic int lg_els_f(input int els);
        return $clog2(els);
    endfunction

    function automatic int ptr_width_f(input int els);
        return $clog2(els) + 1;
    endfunction

    function automatic logic [31:0] ptr_diff_f(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input int          w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (a - b) & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_fifo_reorder_head_scan.sv
// ============================================================================
// bsg_fifo_reorder_head_scan
// Counts contiguous valid slots starting at the head (combinational).
// Revision: 1.0
// ============================================================================
`default_nettype none

module bsg_fifo_reorder_head_scan
    import bsg_fifo_reorder_pkg::*;
#(
    parameter  int els_p        = 8,
    parameter  int deq_els_p    = 1,
    localparam int lg_els_lp    = lg_els_f(els_p),
    localparam int cnt_width_lp = $clog2(deq_els_p + 1)
) (
    input  logic [els_p-1:0]        valid_i,
    input  logic [lg_els_lp-1:0]    rptr_i,
    output logic [cnt_width_lp-1:0] count_o
);

    logic [deq_els_p-1:0] rotated;
    logic [deq_els_p-1:0] scan;
    logic                 run;

    always_comb begin
        // Doubling the vector makes the rotation wrap past slot els_p-1.
        rotated = deq_els_p'({valid_i, valid_i} >> rptr_i);
        scan    = '0;
        run     = 1'b1;
        for (int k = 0; k < deq_els_p; k++) begin
            run     = run & rotated[k];
            scan[k] = run;
        end
        count_o = '0;
        for (int k = 0; k < deq_els_p; k++) begin
            count_o = count_o + cnt_width_lp'(scan[k]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/bsg_fifo_reorder_multi_deq.sv
// ============================================================================
// bsg_fifo_reorder_multi_deq
// Reorder buffer: block allocation, out-of-order writes, multi-entry dequeue.
// Optional write/count checking: BSG_FIFO_REORDER_MULTI_DEQ_WRITE_CHECK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bsg_fifo_reorder_multi_deq
    import bsg_fifo_reorder_pkg::*;
#(
    parameter  int width_p      = 16,
    parameter  int els_p        = 8,
    parameter  int deq_els_p    = 1,
    localparam int lg_els_lp    = lg_els_f(els_p),
    localparam int ptr_width_lp = ptr_width_f(els_p),
    localparam int cnt_width_lp = $clog2(deq_els_p + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [ptr_width_lp-1:0]      alloc_count_i,
    output logic [ptr_width_lp-1:0]      alloc_free_count_o,
    output logic [lg_els_lp-1:0]         alloc_id_o,
    input  logic                         write_v_i,
    input  logic [lg_els_lp-1:0]         write_id_i,
    input  logic [width_p-1:0]           write_data_i,
    output logic [cnt_width_lp-1:0]      deq_v_count_o,
    output logic [deq_els_p*width_p-1:0] deq_data_o,
    output logic [lg_els_lp-1:0]         deq_id_o,
    input  logic [cnt_width_lp-1:0]      deq_yumi_count_i,
    output logic                         empty_o,
    output logic                         error_o
);

    logic [ptr_width_lp-1:0] wptr_q, wptr_d;
    logic [ptr_width_lp-1:0] rptr_q, rptr_d;
    logic [els_p-1:0]        valid_q, valid_d;
    logic [width_p-1:0]      mem_q [els_p];
    logic [width_p-1:0]      mem_d [els_p];

    logic [ptr_width_lp-1:0] used;
    logic [ptr_width_lp-1:0] free;
    logic [cnt_width_lp-1:0] scan_count;
    logic [ptr_width_lp-1:0] alloc_eff;
    logic [cnt_width_lp-1:0] yumi_eff;
    logic                    alloc_ok;
    logic                    yumi_ok;
    logic                    write_ok;

    assign used = ptr_width_lp'(ptr_diff_f(32'(wptr_q), 32'(rptr_q), ptr_width_lp));
    assign free = ptr_width_lp'(els_p) - used;

    bsg_fifo_reorder_head_scan #(
        .els_p     (els_p),
        .deq_els_p (deq_els_p)
    ) u_head_scan (
        .valid_i (valid_q),
        .rptr_i  (rptr_q[lg_els_lp-1:0]),
        .count_o (scan_count)
    );

    assign alloc_free_count_o = free;
    assign alloc_id_o         = wptr_q[lg_els_lp-1:0];
    assign deq_id_o           = rptr_q[lg_els_lp-1:0];
    assign empty_o            = (used == '0);
    assign deq_v_count_o      = (ptr_width_lp'(scan_count) > used)
                              ? cnt_width_lp'(used) : scan_count;

    for (genvar k = 0; k < deq_els_p; k++) begin : g_deq_data
        assign deq_data_o[k*width_p +: width_p] =
            mem_q[rptr_q[lg_els_lp-1:0] + lg_els_lp'(k)];
    end

`ifdef BSG_FIFO_REORDER_MULTI_DEQ_WRITE_CHECK_EN
    logic                 error_q, error_d;
    logic [lg_els_lp-1:0] write_offset;
    logic                 write_alloc;

    assign write_offset = write_id_i - rptr_q[lg_els_lp-1:0];
    assign write_alloc  = ({1'b0, write_offset} < used);
    assign error_o      = error_q;
`else
    assign error_o      = 1'b0;
`endif

    always_comb begin
        alloc_ok = 1'b1;
        yumi_ok  = 1'b1;
        write_ok = write_v_i;
`ifdef BSG_FIFO_REORDER_MULTI_DEQ_WRITE_CHECK_EN
        alloc_ok = (alloc_count_i <= free);
        yumi_ok  = (deq_yumi_count_i <= deq_v_count_o);
        write_ok = write_v_i & write_alloc & ~valid_q[write_id_i];
        error_d  = error_q | ~alloc_ok | ~yumi_ok | (write_v_i & ~write_ok);
`endif
        alloc_eff = alloc_ok ? alloc_count_i : '0;
        yumi_eff  = yumi_ok ? deq_yumi_count_i : '0;
        wptr_d    = wptr_q + alloc_eff;
        rptr_d    = rptr_q + ptr_width_lp'(yumi_eff);
        valid_d   = valid_q;
        mem_d     = mem_q;
        if (write_ok) begin
            valid_d[write_id_i] = 1'b1;
            mem_d[write_id_i]   = write_data_i;
        end
        // Retire clears are applied last so they override a same-slot write.
        for (int i = 0; i < deq_els_p; i++) begin
            if (cnt_width_lp'(i) < yumi_eff) begin
                valid_d[rptr_q[lg_els_lp-1:0] + lg_els_lp'(i)] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            valid_q <= '0;
`ifdef BSG_FIFO_REORDER_MULTI_DEQ_WRITE_CHECK_EN
            error_q <= 1'b0;
`endif
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            valid_q <= valid_d;
`ifdef BSG_FIFO_REORDER_MULTI_DEQ_WRITE_CHECK_EN
            error_q <= error_d;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

`ifndef SYNTHESIS
    a_alloc_range: assert property (@(posedge clk_i) disable iff (reset_i)
        alloc_count_i <= ptr_width_lp'(els_p));
    a_yumi_range: assert property (@(posedge clk_i) disable iff (reset_i)
        deq_yumi_count_i <= cnt_width_lp'(deq_els_p));
`ifndef BSG_FIFO_REORDER_MULTI_DEQ_WRITE_CHECK_EN
    a_alloc_free: assert property (@(posedge clk_i) disable iff (reset_i)
        alloc_count_i <= alloc_free_count_o);
    a_yumi_avail: assert property (@(posedge clk_i) disable iff (reset_i)
        deq_yumi_count_i <= deq_v_count_o);
`endif
`endif

endmodule

`default_nettype wire

// File: tb/tb_bsg_fifo_reorder_multi_deq.sv
// ============================================================================
// tb_bsg_fifo_reorder_multi_deq
// Directed vector table, async reset check, and random traffic vs. a model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bsg_fifo_reorder_multi_deq;

    localparam int W  = 16;
    localparam int E  = 8;
    localparam int D  = 4;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [3:0]    alloc_count_i;
    logic [3:0]    alloc_free_count_o;
    logic [2:0]    alloc_id_o;
    logic          write_v_i;
    logic [2:0]    write_id_i;
    logic [W-1:0]  write_data_i;
    logic [2:0]    deq_v_count_o;
    logic [D*W-1:0] deq_data_o;
    logic [2:0]    deq_id_o;
    logic [2:0]    deq_yumi_count_i;
    logic          empty_o;
    logic          error_o;

    bsg_fifo_reorder_multi_deq #(
        .width_p   (W),
        .els_p     (E),
        .deq_els_p (D)
    ) dut (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .alloc_count_i      (alloc_count_i),
        .alloc_free_count_o (alloc_free_count_o),
        .alloc_id_o         (alloc_id_o),
        .write_v_i          (write_v_i),
        .write_id_i         (write_id_i),
        .write_data_i       (write_data_i),
        .deq_v_count_o      (deq_v_count_o),
        .deq_data_o         (deq_data_o),
        .deq_id_o           (deq_id_o),
        .deq_yumi_count_i   (deq_yumi_count_i),
        .empty_o            (empty_o),
        .error_o            (error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int alloc; int wv; int wid; int wdata; int yumi;
        int e_free; int e_cnt; int e_empty; int e_aid; int e_did; int e_d0;
    } vec_t;

    vec_t vecs [19];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: unbounded head/tail counters plus per-slot state.
    int   m_head, m_tail;
    bit   m_valid [E];
    int   m_mem [E];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int dword(input int k);
        return int'(deq_data_o[k*W +: W]);
    endfunction

    task automatic apply(input int a, input int wv, input int wid, input int wd, input int y);
        alloc_count_i    = 4'(a);
        write_v_i        = wv[0];
        write_id_i       = 3'(wid);
        write_data_i     = W'(wd);
        deq_yumi_count_i = 3'(y);
        @(posedge clk_i);
        #1;
        alloc_count_i    = '0;
        write_v_i        = 1'b0;
        deq_yumi_count_i = '0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        m_head = 0;
        m_tail = 0;
        for (int i = 0; i < E; i++) m_valid[i] = 1'b0;
    endtask

    function automatic int model_cnt();
        int c;
        c = 0;
        while (c < D && c < (m_tail - m_head) && m_valid[(m_head + c) % E]) c++;
        return c;
    endfunction

    task automatic check_reset_vals(input string nm);
        chk({nm, " free"},  int'(alloc_free_count_o), 8);
        chk({nm, " empty"}, int'(empty_o), 1);
        chk({nm, " cnt"},   int'(deq_v_count_o), 0);
        chk({nm, " aid"},   int'(alloc_id_o), 0);
        chk({nm, " did"},   int'(deq_id_o), 0);
        chk({nm, " err"},   int'(error_o), 0);
    endtask

    initial begin
        reset_i          = 1'b1;
        alloc_count_i    = '0;
        write_v_i        = 1'b0;
        write_id_i       = '0;
        write_data_i     = '0;
        deq_yumi_count_i = '0;

        //         alloc wv wid data    yumi free cnt empty aid did d0
        vecs[0]  = '{5, 0, 0, 0,       0,   3,   0,  0,    5,  0,  0};
        vecs[1]  = '{0, 1, 3, 'h00A3,  0,   3,   0,  0,    5,  0,  0};
        vecs[2]  = '{0, 1, 1, 'h00A1,  0,   3,   0,  0,    5,  0,  0};
        vecs[3]  = '{0, 1, 0, 'h00A0,  0,   3,   2,  0,    5,  0,  'h00A0};
        vecs[4]  = '{0, 1, 2, 'h00A2,  0,   3,   4,  0,    5,  0,  'h00A0};
        vecs[5]  = '{0, 1, 4, 'h00A4,  0,   3,   4,  0,    5,  0,  'h00A0};
        vecs[6]  = '{0, 0, 0, 0,       3,   6,   2,  0,    5,  3,  'h00A3};
        vecs[7]  = '{0, 0, 0, 0,       2,   8,   0,  1,    5,  5,  0};
        vecs[8]  = '{1, 0, 0, 0,       0,   7,   0,  0,    6,  5,  0};
        vecs[9]  = '{0, 1, 5, 'h00A5,  0,   7,   1,  0,    6,  5,  'h00A5};
        vecs[10] = '{0, 0, 0, 0,       1,   8,   0,  1,    6,  6,  0};
        vecs[11] = '{4, 0, 0, 0,       0,   4,   0,  0,    2,  6,  0};
        vecs[12] = '{0, 1, 6, 'hB006,  0,   4,   1,  0,    2,  6,  'hB006};
        vecs[13] = '{0, 1, 7, 'hB007,  0,   4,   2,  0,    2,  6,  'hB006};
        vecs[14] = '{0, 1, 0, 'hB000,  0,   4,   3,  0,    2,  6,  'hB006};
        vecs[15] = '{0, 1, 1, 'hB001,  0,   4,   4,  0,    2,  6,  'hB006};
        vecs[16] = '{0, 0, 0, 0,       4,   8,   0,  1,    2,  2,  0};
        vecs[17] = '{8, 0, 0, 0,       0,   0,   0,  0,    2,  2,  0};
        vecs[18] = '{0, 1, 2, 'hC002,  0,   0,   1,  0,    2,  2,  'hC002};

        #2;
        check_reset_vals("reset");
        do_reset();
        check_reset_vals("release");

        for (int i = 0; i < 19; i++) begin
            apply(vecs[i].alloc, vecs[i].wv, vecs[i].wid, vecs[i].wdata, vecs[i].yumi);
            chk($sformatf("row%0d free", i),  int'(alloc_free_count_o), vecs[i].e_free);
            chk($sformatf("row%0d cnt", i),   int'(deq_v_count_o),      vecs[i].e_cnt);
            chk($sformatf("row%0d empty", i), int'(empty_o),            vecs[i].e_empty);
            chk($sformatf("row%0d aid", i),   int'(alloc_id_o),         vecs[i].e_aid);
            chk($sformatf("row%0d did", i),   int'(deq_id_o),           vecs[i].e_did);
            chk($sformatf("row%0d err", i),   int'(error_o),            0);
            if (vecs[i].e_cnt > 0)
                chk($sformatf("row%0d d0", i), dword(0), vecs[i].e_d0);
            if (i == 3)
                chk("row3 d1", dword(1), 'h00A1);
            if (i == 15) begin
                chk("wrap d1", dword(1), 'hB007);
                chk("wrap d2", dword(2), 'hB000);
                chk("wrap d3", dword(3), 'hB001);
            end
        end

        // Asynchronous reset between clock edges.
        #3;
        reset_i = 1'b1;
        #1;
        check_reset_vals("async");
        #2;
        reset_i = 1'b0;
        m_head = 0;
        m_tail = 0;
        for (int i = 0; i < E; i++) m_valid[i] = 1'b0;
        @(posedge clk_i);
        #1;
        check_reset_vals("post_async");

`ifdef BSG_FIFO_REORDER_MULTI_DEQ_WRITE_CHECK_EN
        do_reset();
        apply(5, 0, 0, 0, 0);
        apply(0, 1, 5, 'h0055, 0);
        chk("unalloc err", int'(error_o), 1);
        chk("unalloc cnt", int'(deq_v_count_o), 0);
        apply(0, 0, 0, 0, 0);
        chk("sticky err", int'(error_o), 1);
        do_reset();
        chk("err cleared", int'(error_o), 0);
        apply(5, 0, 0, 0, 0);
        apply(0, 1, 0, 'h0011, 0);
        chk("first write err", int'(error_o), 0);
        apply(0, 1, 0, 'h0022, 0);
        chk("dbl write err", int'(error_o), 1);
        chk("dbl write data", dword(0), 'h0011);
        chk("dbl write cnt", int'(deq_v_count_o), 1);
`endif

        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            int used, free, a, wv, wid, wd, y, ec;
            int pend[$];
            used = m_tail - m_head;
            free = E - used;
            a = ($urandom_range(3, 0) == 0) ? int'($urandom_range(free, 0))
                                            : int'($urandom_range((free < 2) ? free : 2, 0));
            pend.delete();
            for (int k = 0; k < used; k++)
                if (!m_valid[(m_head + k) % E]) pend.push_back((m_head + k) % E);
            wv = 0; wid = 0;
            wd = int'($urandom_range(16'hFFFF, 0));
            if (pend.size() > 0 && $urandom_range(3, 0) != 0) begin
                wv  = 1;
                wid = pend[$urandom_range(pend.size() - 1, 0)];
            end
            ec = model_cnt();
            y  = int'($urandom_range(ec, 0));
            apply(a, wv, wid, wd, y);

            if (wv != 0) begin
                m_valid[wid] = 1'b1;
                m_mem[wid]   = wd;
            end
            for (int k = 0; k < y; k++) m_valid[(m_head + k) % E] = 1'b0;
            m_head += y;
            m_tail += a;

            ec = model_cnt();
            chk($sformatf("rnd%0d free", cyc),  int'(alloc_free_count_o), E - (m_tail - m_head));
            chk($sformatf("rnd%0d cnt", cyc),   int'(deq_v_count_o), ec);
            chk($sformatf("rnd%0d empty", cyc), int'(empty_o), (m_tail == m_head) ? 1 : 0);
            chk($sformatf("rnd%0d aid", cyc),   int'(alloc_id_o), m_tail % E);
            chk($sformatf("rnd%0d did", cyc),   int'(deq_id_o), m_head % E);
            chk($sformatf("rnd%0d err", cyc),   int'(error_o), 0);
            for (int k = 0; k < ec; k++)
                chk($sformatf("rnd%0d d%0d", cyc, k), dword(k), m_mem[(m_head + k) % E]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bsg_fifo_reorder_multi_deq.md
Name: bsg_fifo_reorder_multi_deq

Overview:
- Reorder buffer with variable-count allocation, random-access writes, and in-order multi-entry dequeue.
- A requester allocates a block of N contiguous slot IDs per cycle. Responders write results out of order by ID.
- The consumer retires up to deq_els_p contiguous completed entries per cycle from the head.
- Used for out-of-order memory/network response reassembly where throughput above one entry per cycle is required.

Parameters:
- width_p, (none, required), payload bits per entry.
- els_p, (none, required), number of slots; must be a power of two, at least 2.
- deq_els_p, 1, maximum entries retired per cycle; 1 to els_p.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset, asynchronous, active-high.
- alloc_count_i  in  BSG_WIDTH(els_p)  number of slots to allocate this cycle (0..els_p).
- alloc_free_count_o  out  BSG_WIDTH(els_p)  currently unallocated slots.
- alloc_id_o  out  lg(els_p)  base ID of the block allocated this cycle.
- write_v_i  in  1  write strobe.
- write_id_i  in  lg(els_p)  slot written.
- write_data_i  in  width_p  payload.
- deq_v_count_o  out  BSG_WIDTH(deq_els_p)  contiguous written entries at head, capped at deq_els_p.
- deq_data_o  out  deq_els_p*width_p  entry k at bits [k*width_p +: width_p], entry 0 = head.
- deq_id_o  out  lg(els_p)  head ID.
- deq_yumi_count_i  in  BSG_WIDTH(deq_els_p)  entries retired this cycle.
- empty_o  out  1  no allocated entries.
- error_o  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- State: wptr_r and rptr_r, each lg(els_p)+1 bits with a wrap bit; valid_r[els_p]; flop storage array mem_r[els_p].
- Used count = wptr_r - rptr_r, taken modulo 2^(lg+1). Free count = els_p - used.
- On reset (async assert):
  - wptr_r = rptr_r = 0; valid_r = 0; error_o = 0.
  - alloc_free_count_o = els_p, alloc_id_o = 0, deq_v_count_o = 0, deq_id_o = 0, empty_o = 1.
  - mem_r contents are not reset; deq_data_o is don't-care while deq_v_count_o = 0.
- Allocation:
  - alloc_id_o = wptr_r[lg-1:0].
  - Allocated IDs are alloc_id_o + i for i < alloc_count_i, taken modulo els_p (wraps).
  - On the clock edge, wptr_r += alloc_count_i.
  - Caller must keep alloc_count_i <= alloc_free_count_o.
  - Allocating els_p when empty is legal: full, free = 0.
- Write: when write_v_i, mem_r[write_id_i] <= write_data_i and valid_r[write_id_i] <= 1. Latency write to visibility is 1 cycle; no bypass.
- Dequeue view, combinational from registers only (no input-to-output paths):
  - deq_v_count_o = number of consecutive set bits in valid_r, starting at rptr_r and going upward modulo els_p.
  - That count is capped at deq_els_p and at the used count.
  - deq_data_o entry k = mem_r[rptr_r + k modulo els_p].
- Retire: on the edge, rptr_r += deq_yumi_count_i, and valid_r clears for the slots rptr_r .. rptr_r + deq_yumi_count_i - 1. Caller must keep deq_yumi_count_i <= deq_v_count_o.
- Simultaneous events:
  - Allocate and retire in the same cycle are independent; free count changes by (retire - alloc).
  - A write to the slot being retired cannot occur legally, since that slot is already valid. If it does occur anyway, clear wins.
  - A write and a retire to different slots in the same cycle both take effect.
- empty_o = (used == 0). Full: free = 0.
- Wrap: the pointer wrap bit disambiguates full from empty. The head scan wraps across slot els_p-1 to slot 0.

Optional Feature:
- Macro: BSG_FIFO_REORDER_MULTI_DEQ_WRITE_CHECK_EN.
- Defined: a write is dropped (no mem or valid update) and error_o sets sticky if either holds:
  - write_id_i is not currently allocated, or
  - valid_r[write_id_i] is already 1 (double write).
  - Over-allocation and over-retire also set error_o, and the offending count is ignored that cycle.
  - error_o clears only on reset.
- Undefined: error_o is tied 0. All writes are accepted unconditionally; illegal counts give undefined results.
- Simulation-only assertions exist in both builds.

Decomposition:
- Package bsg_fifo_reorder_pkg holds:
  - pointer-width helper constants, lg_els_lp and ptr_width_lp = lg_els_lp+1;
  - a function for the pointer modulo-difference.
- One sub-module, bsg_fifo_reorder_head_scan:
  - rotates valid_r by rptr_r;
  - runs a low-to-high AND scan over deq_els_p bits;
  - popcounts the scan output to produce deq_v_count_o before the used-count cap;
  - purely combinational.

Test Plan (els_p=8, deq_els_p=4, width_p=16):
- Reset release: alloc_free_count_o=8, empty_o=1, deq_v_count_o=0, error_o=0.
- Allocate 5 at ID 0. Write IDs 3,1,0 with data 0xA3,0xA1,0xA0. Next cycle deq_v_count_o=2, data entries 0xA0,0xA1. Write ID 2, then deq_v_count_o=4 (IDs 0-3).
- Retire 3 with all 5 written: rptr goes 0→3, deq_id_o=3, deq_v_count_o=2, free=6.
- Wrap: advance pointers to 6, allocate 4 (IDs 6,7,0,1), write all four. deq_v_count_o=4 and deq_data_o order is 6,7,0,1. Retire 4 gives empty_o=1.
- Full: allocate 8 in one cycle. free=0, empty_o=0, alloc_id_o unchanged until the next allocation.
- Macro defined: write to unallocated ID 5, or write ID 0 twice → error_o=1 next cycle, data unchanged. Assert reset mid-operation → all outputs return to reset values immediately (async).
